// File: rtl/gcode_line_sequencer.sv
// gcode_line_sequencer: per-line field capture, ASCII-to-binary conversion, motion dispatch and host acknowledge
module gcode_line_sequencer #(
  parameter logic [7:0]  p_ACK_CHAR       = 8'd75,
  parameter logic [7:0]  p_ERR_CHAR       = 8'd69,
  parameter logic [31:0] p_TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic        i_Clock50MHz,
  input  logic        i_ResetN,
  input  logic        i_LineComplete,
  input  logic [47:0] i_XValue,
  input  logic [47:0] i_YValue,
  input  logic [47:0] i_ZValue,
  input  logic [47:0] i_EValue,
  input  logic        i_XDirection,
  input  logic        i_YDirection,
  input  logic        i_ZDirection,
  input  logic        i_EDirection,
  input  logic [23:0] i_M1Value,
  input  logic [23:0] i_M2Value,
  input  logic [23:0] i_M3Value,
  input  logic        i_MotionDone,
  input  logic        i_TxBusy,
  output logic [19:0] o_XSteps,
  output logic [19:0] o_YSteps,
  output logic [19:0] o_ZSteps,
  output logic [19:0] o_ESteps,
  output logic [3:0]  o_Dir,
  output logic        o_MotionStart,
  output logic [9:0]  o_HotEndTemp,
  output logic [9:0]  o_BedTemp,
  output logic [9:0]  o_FanSpeed,
  output logic        o_TxStart,
  output logic [7:0]  o_TxData,
  output logic        o_Busy,
  output logic        o_Error
);
  typedef enum logic [2:0] {IDLE, CAPTURE, CONVERT, DISPATCH, WAIT_MOTION, ACK} state_t;
  state_t        state_q;
  logic [1:0]    rst_sync_q;
  logic          rst_n, lc_q, rise, digit, bad, stop_eff, moving, timeout, tx_err, send;
  logic [263:0]  sh_q;
  logic [19:0]   acc_q [8];
  logic [19:0]   acc_nx;
  logic [7:0]    byt;
  logic [5:0]    b_q;
  logic [2:0]    fld, mnz_q;
  logic          stop_q, err_q, ovr_q;
  logic [31:0]   t_q;

  // Reset asserts immediately, releases on a clock edge
  always_ff @(posedge i_Clock50MHz or negedge i_ResetN)
    if (!i_ResetN) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};

  assign rst_n = rst_sync_q[1];

  // Byte classification for the current conversion step, plus dispatch/acknowledge conditions
  always_comb begin
    rise     = i_LineComplete & ~lc_q;
    byt      = sh_q[263:256];
    fld      = b_q < 6'd6  ? 3'd0 :
               b_q < 6'd12 ? 3'd1 :
               b_q < 6'd18 ? 3'd2 :
               b_q < 6'd24 ? 3'd3 :
               b_q < 6'd27 ? 3'd4 :
               b_q < 6'd30 ? 3'd5 : 3'd6;
    stop_eff = stop_q & !(b_q inside {6'd0, 6'd6, 6'd12, 6'd18, 6'd24, 6'd27, 6'd30});
    digit    = byt >= 8'h30 && byt <= 8'h39;
    bad      = byt != 8'h00 && byt != 8'h2E && !digit;
    acc_nx   = acc_q[fld] * 20'd10 + {16'd0, byt[3:0]};
    moving   = |{acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
    timeout  = t_q == p_TIMEOUT_CYCLES - 32'd1;
    tx_err   = err_q | ovr_q | (state_q == WAIT_MOTION && !i_MotionDone);
    send     = !i_TxBusy && (state_q == ACK || (state_q == WAIT_MOTION && (i_MotionDone || timeout)));
  end

  // Line sequencing FSM with registered outputs; acknowledge is issued straight from WAIT_MOTION when the UART is free
  always_ff @(posedge i_Clock50MHz or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      lc_q          <= 1'b0;
      sh_q          <= '0;
      for (int i = 0; i < 8; i++) acc_q[i] <= '0;
      b_q           <= '0;
      mnz_q         <= '0;
      stop_q        <= 1'b0;
      err_q         <= 1'b0;
      ovr_q         <= 1'b0;
      t_q           <= '0;
      o_XSteps      <= '0;
      o_YSteps      <= '0;
      o_ZSteps      <= '0;
      o_ESteps      <= '0;
      o_Dir         <= '0;
      o_MotionStart <= 1'b0;
      o_HotEndTemp  <= '0;
      o_BedTemp     <= '0;
      o_FanSpeed    <= '0;
      o_TxStart     <= 1'b0;
      o_TxData      <= '0;
      o_Busy        <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      lc_q          <= i_LineComplete;
      o_MotionStart <= 1'b0;
      o_TxStart     <= 1'b0;
      if (rise && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (rise) begin
          state_q <= CAPTURE;
          o_Busy  <= 1'b1;
        end
        CAPTURE: begin
          sh_q    <= {i_XValue, i_YValue, i_ZValue, i_EValue, i_M1Value, i_M2Value, i_M3Value};
          o_Dir   <= {i_EDirection, i_ZDirection, i_YDirection, i_XDirection};
          mnz_q   <= {|i_M3Value, |i_M2Value, |i_M1Value};
          for (int i = 0; i < 8; i++) acc_q[i] <= '0;
          b_q     <= '0;
          stop_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= CONVERT;
        end
        CONVERT: begin
          if (!stop_eff && digit) acc_q[fld] <= acc_nx;
          if (!stop_eff && bad) err_q <= 1'b1;
          stop_q  <= stop_eff | byt == 8'h2E | bad;
          sh_q    <= sh_q << 8;
          b_q     <= b_q + 6'd1;
          if (b_q == 6'd32) state_q <= DISPATCH;
        end
        DISPATCH: begin
          t_q     <= '0;
          state_q <= ACK;
          if (!err_q) begin
            o_XSteps <= acc_q[0];
            o_YSteps <= acc_q[1];
            o_ZSteps <= acc_q[2];
            o_ESteps <= acc_q[3];
            if (mnz_q[0]) o_HotEndTemp <= acc_q[4][9:0];
            if (mnz_q[1]) o_BedTemp <= acc_q[5][9:0];
            if (mnz_q[2]) o_FanSpeed <= acc_q[6][9:0];
            if (moving) begin
              o_MotionStart <= 1'b1;
              state_q       <= WAIT_MOTION;
            end
          end
        end
        WAIT_MOTION:
          if (i_MotionDone || timeout) begin
            err_q   <= tx_err;
            state_q <= ACK;
          end else t_q <= t_q + 32'd1;
        ACK: ;
        default: state_q <= IDLE;
      endcase
      if (send) begin
        o_TxStart <= 1'b1;
        o_TxData  <= tx_err ? p_ERR_CHAR : p_ACK_CHAR;
        o_Error   <= tx_err;
        ovr_q     <= rise;
        o_Busy    <= 1'b0;
        state_q   <= IDLE;
      end
    end
endmodule

// File: doc/gcode_line_sequencer.md
# gcode_line_sequencer

Sequences every decoded G-code line from the serial G-code decoder through to the machine. On each line-complete strobe it captures the ASCII fields and converts them to binary counts one byte per cycle. It then dispatches motion to the stepper motion executor and latches heater/fan setpoints. It sends one acknowledge byte to the UART transmitter so the host releases the next line.

## Interface
- p_ACK_CHAR, 8'd75 ('K'): byte sent after a line completes successfully.
- p_ERR_CHAR, 8'd69 ('E'): byte sent after a line fails.
- p_TIMEOUT_CYCLES, 32'd500_000_000: maximum wait for i_MotionDone (10 s at 50 MHz).
- i_Clock50MHz  in  1  system clock.
- i_ResetN  in  1  reset, asynchronous, active-low.
- i_LineComplete  in  1  decoder line-complete level; high for at least 1 cycle per line.
- i_XValue, i_YValue, i_ZValue, i_EValue  in  48 each  six ASCII bytes, right-aligned, 8'h00-padded, MS byte first.
- i_XDirection, i_YDirection, i_ZDirection, i_EDirection  in  1 each  1 = negative.
- i_M1Value, i_M2Value, i_M3Value  in  24 each  three ASCII bytes (hot-end, bed, fan).
- i_MotionDone  in  1  motion executor finished (level or pulse).
- i_TxBusy  in  1  UART transmitter busy.
- o_XSteps, o_YSteps, o_ZSteps, o_ESteps  out  20 each  binary magnitude.
- o_Dir  out  4  {E,Z,Y,X} directions, latched at capture.
- o_MotionStart  out  1  one-cycle start pulse.
- o_HotEndTemp, o_BedTemp, o_FanSpeed  out  10 each  binary setpoints.
- o_TxStart  out  1  one-cycle transmit request.
- o_TxData  out  8  byte to transmit.
- o_Busy  out  1  high in every state except IDLE.
- o_Error  out  1  high from the error ACK until the next successful ACK.

## Operation
- **Reset:** all outputs 0 and state IDLE.
- **Line detection:** register i_LineComplete and act on the rising edge only.
- **Overrun:** a rising edge outside IDLE is ignored and sets an internal overrun flag. That line ends with p_ERR_CHAR.
- **States:** IDLE, CAPTURE, CONVERT, DISPATCH, WAIT_MOTION, ACK.
- **IDLE → CAPTURE** on a rising edge.
- **CAPTURE** (1 cycle): snapshot all input fields and directions into shadow registers; clear the accumulators and the line error flag.
- **CONVERT:** processes one byte per cycle in fixed order: X, Y, Z, E (6 bytes each), then M1, M2, M3 (3 bytes each), 33 cycles in total.
  - Byte 8'h00: skipped.
  - '0'..'9': acc = acc*10 + (byte - 48).
  - '.' (46): the remaining bytes of that field are ignored, so the fraction is truncated.
  - Any other byte: sets the line error flag and the field's value is discarded.
  - Width: X/Y/Z/E accumulators are 20 bits (999999 maximum); M accumulators are 10 bits (999 maximum). No overflow is possible.
- **DISPATCH** (1 cycle):
  - If the line error flag is set, skip to ACK.
  - Otherwise load the step outputs and latch any M setpoint whose shadow field is nonzero.
  - If any step value is nonzero: pulse o_MotionStart and go to WAIT_MOTION. Otherwise go to ACK.
- **WAIT_MOTION:**
  - Leave on i_MotionDone = 1.
  - If the timeout counter reaches p_TIMEOUT_CYCLES, set the line error flag and go to ACK.
  - A reset here aborts the line, and no ACK is sent.
- **ACK:**
  - Wait while i_TxBusy = 1.
  - Then pulse o_TxStart with o_TxData = p_ERR_CHAR if error or overrun, else p_ACK_CHAR.
  - Update o_Error, clear overrun, and return to IDLE.
- **Holding values:** step outputs and setpoints keep their values until the next successful DISPATCH.

## Timing
- Capture happens 1 cycle after the registered rising edge of i_LineComplete.
- o_MotionStart fires 35 cycles after that edge, i.e. 1 cycle after CONVERT completes.
- For a non-motion line, o_TxStart fires 36 cycles after the edge when i_TxBusy = 0.
- After i_MotionDone, o_TxStart fires 1 cycle later when the transmitter is idle.
- i_MotionDone asserted in the same cycle as DISPATCH is ignored; only WAIT_MOTION samples it.
- i_LineComplete held high for 100 cycles produces exactly one line.
- Asynchronous reset takes effect immediately in any state. Release is synchronised to i_Clock50MHz.

## Test plan
- **Valid motion line:** X = 48'h000000313230 ("120"), Y = "-" direction with "45", Z = E = 0, then motion done after 50 cycles → o_XSteps = 120, o_YSteps = 45, o_Dir = 4'b0010, one o_MotionStart, then o_TxData = 8'h4B, o_Error = 0.
- **Temperature-only line:** M1 = 24'h323030 ("200"), all axes 0 → o_HotEndTemp = 200, no o_MotionStart, 'K' sent 36 cycles after the edge.
- **Fraction and invalid byte:** X = "12.75" → o_XSteps = 12. Y containing 'A' → no o_MotionStart, 'E' sent, o_Error = 1, previous step outputs unchanged.
- **Motion timeout:** p_TIMEOUT_CYCLES = 100 and i_MotionDone held low → 'E' sent 100 cycles after o_MotionStart.
- **Overrun and transmitter back-pressure:** a second i_LineComplete edge during WAIT_MOTION → ignored, and the line ends with 'E'. i_TxBusy held high for 20 cycles → o_TxStart delayed until busy drops.
- **Reset mid-line:** i_ResetN low during CONVERT → all outputs 0, no o_TxStart, and the next line is processed normally.
